// File: rtl/fetch_ifid_stage.sv
// fetch_ifid_stage: PC generation, single-outstanding imem fetch handshake and IF/ID register.
module fetch_ifid_stage #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_pc,
    input  logic [63:0] branch_imm,
    output logic [31:0] id_instruc,
    output logic [63:0] id_pc,
    output logic        id_valid
);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t      state, state_nx;
    logic [63:0] pc, pc_nx, pend, pend_nx, skid_pc, target, pc_inc;
    logic [31:0] skid_instr;
    logic        accept, skid_ld, ld_mem, ld_skid;

    assign accept    = !id_valid || !stall;
    assign target    = branch_pc + (branch_imm << 1);
    assign pc_inc    = pc + 64'(PC_STEP);
    assign imem_req  = (state == WAIT) || (state == DROP);
    assign imem_addr = pc;
    assign ld_mem    = (state == WAIT) && imem_valid && !branch_taken && accept;
    assign ld_skid   = (state == HOLD) && !branch_taken && !stall;

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        pend_nx  = pend;
        skid_ld  = 1'b0;
        case (state)
            IDLE: state_nx = WAIT;
            WAIT: begin
                if (branch_taken) begin
                    if (imem_valid) begin
                        pc_nx = target;
                    end else begin
                        pend_nx  = target;
                        state_nx = DROP;
                    end
                end else if (imem_valid) begin
                    pc_nx = pc_inc;
                    if (!accept) begin
                        skid_ld  = 1'b1;
                        state_nx = HOLD;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    pc_nx    = target;
                    state_nx = WAIT;
                end else if (!stall) begin
                    state_nx = WAIT;
                end
            end
            DROP: begin
                // Response in flight belongs to the squashed fetch; retire it before redirecting.
                if (branch_taken) pend_nx = target;
                if (imem_valid) begin
                    pc_nx    = branch_taken ? target : pend;
                    state_nx = WAIT;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend       <= 64'h0;
            skid_pc    <= 64'h0;
            skid_instr <= NOP;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            pend  <= pend_nx;
            if (skid_ld) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

    // Flush wins over stall; an unconsumed slot drains when nothing new arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid   <= 1'b0;
            id_pc      <= 64'h0;
            id_instruc <= NOP;
        end else if (branch_taken) begin
            id_valid   <= 1'b0;
            id_instruc <= NOP;
        end else if (ld_mem) begin
            id_valid   <= 1'b1;
            id_instruc <= imem_rdata;
            id_pc      <= pc;
        end else if (ld_skid) begin
            id_valid   <= 1'b1;
            id_instruc <= skid_instr;
            id_pc      <= skid_pc;
        end else if (accept) begin
            id_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_ifid_stage.sv
// tb_fetch_ifid_stage: directed checks of fetch sequencing, stall, redirects and async reset.
module tb_fetch_ifid_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_valid, stall = 1'b0, branch_taken = 1'b0, id_valid;
    logic [63:0] imem_addr, branch_pc = 64'h0, branch_imm = 64'h0, id_pc;
    logic [31:0] imem_rdata, id_instruc;
    int          lat = 0, cnt = 0, checks = 0, failures = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    fetch_ifid_stage dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .stall(stall),
        .branch_taken(branch_taken), .branch_pc(branch_pc), .branch_imm(branch_imm),
        .id_instruc(id_instruc), .id_pc(id_pc), .id_valid(id_valid)
    );

    always #5 clk = ~clk;

    // Memory returns its own address as data after lat waiting cycles.
    assign imem_valid = imem_req && (cnt >= lat);
    assign imem_rdata = imem_addr[31:0];
    always @(posedge clk or posedge reset) begin
        if (reset) cnt <= 0;
        else if (imem_valid) cnt <= 0;
        else if (imem_req) cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        nxt();
        check("rst_valid", id_valid, 0);
        check("rst_instr", id_instruc, NOP);
        check("rst_pc", id_pc, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        reset = 1'b0;
        nxt();
        check("t1_req", imem_req, 1);
        check("t1_first_edge", id_valid, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            check("t1_valid", id_valid, 1);
            check("t1_pc", id_pc, 64'(i * 4));
            check("t1_instr", id_instruc, 64'(i * 4));
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("t2_frozen_pc", id_pc, 64'd12);
            check("t2_frozen_v", id_valid, 1);
            check("t2_hold_req", imem_req, 0);
        end
        check("t2_hold_addr", imem_addr, 64'd20);
        stall = 1'b0;
        nxt();
        check("t2_skid_pc", id_pc, 64'd16);
        check("t2_skid_instr", id_instruc, 64'd16);
        check("t2_resume_req", imem_req, 1);
        nxt();
        check("t2_next_pc", id_pc, 64'd20);
        branch_taken = 1'b1;
        branch_pc    = 64'h40;
        branch_imm   = 64'h10;
        nxt();
        branch_taken = 1'b0;
        check("t3_flush_v", id_valid, 0);
        check("t3_flush_nop", id_instruc, NOP);
        check("t3_addr", imem_addr, 64'h60);
        nxt();
        check("t3_pc", id_pc, 64'h60);
        check("t3_valid", id_valid, 1);
        lat = 3;
        nxt();
        check("t4_drain", id_valid, 0);
        branch_taken = 1'b1;
        branch_pc    = 64'h1f0;
        branch_imm   = 64'h8;
        nxt();
        branch_taken = 1'b0;
        check("t4_drop_addr", imem_addr, 64'h64);
        check("t4_drop_req", imem_req, 1);
        nxt();
        check("t4_stale_resp", id_valid, 0);
        nxt();
        check("t4_redirect_addr", imem_addr, 64'h200);
        check("t4_no_stale", id_valid, 0);
        for (int i = 0; i < 10; i++) begin
            nxt();
            if (id_valid) break;
        end
        check("t4_timeout", id_valid, 1);
        check("t4_pc", id_pc, 64'h200);
        check("t4_instr", id_instruc, 64'h200);
        lat = 0;
        branch_taken = 1'b1;
        branch_pc    = 64'h100;
        branch_imm   = 64'hffff_ffff_ffff_fffc;
        nxt();
        branch_taken = 1'b0;
        check("t5_neg_addr", imem_addr, 64'hf8);
        nxt();
        check("t5_neg_pc", id_pc, 64'hf8);
        branch_taken = 1'b1;
        branch_pc    = 64'h0;
        branch_imm   = 64'hffff_ffff_ffff_fffe;
        nxt();
        branch_taken = 1'b0;
        check("t5_wrap_addr", imem_addr, 64'hffff_ffff_ffff_fffc);
        nxt();
        check("t5_wrap_pc", id_pc, 64'hffff_ffff_ffff_fffc);
        check("t5_wrap_instr", id_instruc, 64'hffff_fffc);
        nxt();
        check("t5_wrap_next", id_pc, 64'h0);
        check("t5_wrap_valid", id_valid, 1);
        stall = 1'b1;
        nxt();
        check("t6_in_hold", imem_req, 0);
        #2 reset = 1'b1;
        #1;
        check("t6_async_v", id_valid, 0);
        check("t6_async_addr", imem_addr, 0);
        check("t6_async_req", imem_req, 0);
        check("t6_async_nop", id_instruc, NOP);
        stall = 1'b0;
        nxt();
        reset = 1'b0;
        nxt();
        check("t6_restart_v", id_valid, 0);
        check("t6_restart_req", imem_req, 1);
        nxt();
        check("t6_first_v", id_valid, 1);
        check("t6_first_pc", id_pc, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
